button_irq_ctrl: RTL and testbench
==================================

BUTTON_IRQ_CTRL -- requirements
Module: button_irq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of button inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a new level; legal range 2..2^20.
REQ-003 clk  input  1  sole clock; all logic rises on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_port  input  WIDTH  raw asynchronous button levels, active-low (pressed = 0).
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 irq  output  1  level interrupt to the CPU.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use; sync[i] is the second-flop output.
REQ-013 Each bit SHALL have an independent debounce FSM with states STABLE and COUNTING, a counter wide enough for DEBOUNCE_CYCLES, and a debounced level db[i].
REQ-014 STABLE: if sync[i] == db[i], stay and hold counter at 0; else go to COUNTING with counter = 1.
REQ-015 COUNTING: if sync[i] == db[i], return to STABLE and clear the counter; else if counter == DEBOUNCE_CYCLES-1, toggle db[i], clear the counter, go to STABLE; else increment the counter.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave db unchanged; worst-case in_port-to-db latency = 2 + DEBOUNCE_CYCLES cycles.
REQ-017 A press event SHALL be a 1->0 transition of db[i] (detected against db delayed one cycle); it SHALL set edgecapture[i] in the cycle after db changes.
REQ-018 Register map (reads, bits above WIDTH return 0): addr 0 = db (debounced level); addr 1 = raw sync; addr 2 = irqmask (R/W); addr 3 = edgecapture.
REQ-019 A write with address 2 SHALL load irqmask <= writedata[WIDTH-1:0]; writes to addresses 0 and 1 SHALL be ignored.
REQ-020 A write with address 3 SHALL clear each edgecapture bit whose writedata bit is 1 (write-1-to-clear).
REQ-021 When a press event and a clear hit the same bit in the same cycle, set SHALL win and the bit SHALL stay 1.
REQ-022 readdata SHALL be registered every cycle from the addressed register, with one-cycle read latency and no wait states; chipselect does not gate the read mux.
REQ-023 irq SHALL be registered: irq <= |(edgecapture & irqmask), so it follows register changes by one cycle.
REQ-024 Changing irqmask SHALL never alter edgecapture; masked events are still captured.

Reset
REQ-025 While reset = 1 at a clock edge: synchronizer flops, db and its delayed copy SHALL load all-ones (released); FSMs SHALL enter STABLE with counters at 0; irqmask, edgecapture, readdata and irq SHALL load 0.
REQ-026 Reset asserted during COUNTING SHALL abort the count, and no press event SHALL occur as a result of reset.
REQ-027 After reset is released, a button already held low SHALL be accepted after the normal debounce delay and SHALL produce one press event.

Verification (DEBOUNCE_CYCLES = 4, WIDTH = 4)
REQ-028 Clean press: in_port[0] 1->0 and held -> db[0] = 0 exactly 6 cycles later; edgecapture = 0x1 one cycle after that; with irqmask = 0x1, irq = 1 one further cycle later.
REQ-029 Glitch: in_port[1] low for 3 cycles, then high -> db, edgecapture and irq all remain unchanged.
REQ-030 Set/clear collision: write 0x4 to address 3 in the same cycle bit 2's press event fires -> edgecapture[2] = 1 and irq stays asserted.
REQ-031 Mask and clear: edgecapture = 0x3 and irqmask = 0x0 -> irq = 0; write irqmask = 0x2 -> irq = 1 after 2 cycles; write 0x2 to address 3 -> edgecapture = 0x1 and irq = 0.
REQ-032 Reset mid-count: assert reset at counter = 2 with in_port[3] low -> after release, db[3] = 0 after 6 cycles and exactly one event is captured.
REQ-033 Readback: read address 2 after writing 0xFFFFFFF5 -> readdata = 0x00000005 one cycle after the read address is presented.

Source files
------------

// File: rtl/button_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the button interrupt controller.
// Word-addressed, one-cycle registered read, no wait states.
interface button_irq_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/button_irq_ctrl.sv
// Debounced push-button port with edge capture and a masked level irq.
// Buttons are active-low; a press is a 1->0 change of the debounced level.
module button_irq_ctrl #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   button_irq_ctrl_if.slave bus,
   output logic             irq
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STABLE, COUNTING} db_state_e;

   logic [WIDTH-1:0] meta_q, sync_q;
   logic [WIDTH-1:0] db_q, db_d, db_dly_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] ec_q, ec_d;
   logic [WIDTH-1:0] press;
   logic [31:0]      rd_q, rd_d;
   logic             irq_q, irq_d;
   logic             wr_en;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      db_state_e     state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          bit_d;

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= STABLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         bit_d   = db_q[i];
         unique case (state_q)
            STABLE: begin
               if (sync_q[i] != db_q[i]) begin
                  state_d = COUNTING;
                  cnt_d   = CW'(1);
               end else begin
                  cnt_d = '0;
               end
            end
            COUNTING: begin
               if (sync_q[i] == db_q[i]) begin
                  state_d = STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  bit_d   = ~db_q[i];
                  state_d = STABLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end

      assign db_d[i] = bit_d;
   end

   assign wr_en = bus.chipselect & ~bus.write_n;
   assign press = db_dly_q & ~db_q;
   assign unused_wdata = ^bus.writedata;

   always_comb begin
      mask_d = mask_q;
      ec_d   = ec_q;
      if (wr_en && bus.address == 2'd2) begin
         mask_d = bus.writedata[WIDTH-1:0];
      end
      if (wr_en && bus.address == 2'd3) begin
         ec_d = ec_q & ~bus.writedata[WIDTH-1:0];
      end
      // A press in the same cycle as its clear must survive
      ec_d  = ec_d | press;
      irq_d = |(ec_q & mask_q);
      rd_d  = '0;
      unique case (bus.address)
         2'd0: rd_d = 32'(db_q);
         2'd1: rd_d = 32'(sync_q);
         2'd2: rd_d = 32'(mask_q);
         2'd3: rd_d = 32'(ec_q);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q   <= '1;
         sync_q   <= '1;
         db_q     <= '1;
         db_dly_q <= '1;
         mask_q   <= '0;
         ec_q     <= '0;
         rd_q     <= '0;
         irq_q    <= 1'b0;
      end else begin
         meta_q   <= in_port;
         sync_q   <= meta_q;
         db_q     <= db_d;
         db_dly_q <= db_q;
         mask_q   <= mask_d;
         ec_q     <= ec_d;
         rd_q     <= rd_d;
         irq_q    <= irq_d;
      end
   end

   assign bus.readdata = rd_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Self-checking bench for button_irq_ctrl with WIDTH=4, DEBOUNCE_CYCLES=4.
// Register expectations flow through a queue that is retired one cycle later.
module tb_button_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_port;
   logic       irq;

   button_irq_ctrl_if bus ();

   button_irq_ctrl #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_port (in_port),
      .bus     (bus),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] exp;
      logic [31:0] msk;
   } sb_t;

   vec_t vt[16];
   sb_t  sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(
      input string n, input logic [1:0] a, input logic w,
      input logic [31:0] d, input logic [31:0] e, input logic q
   );
      vec_t v;
      v.name = n; v.addr = a; v.wr = w;
      v.wdata = d; v.exp_rd = e; v.exp_irq = q;
      return v;
   endfunction

   task automatic cmp(
      input string n, input logic [31:0] act, input logic [31:0] exp
   );
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [1:0] a);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = a;
      bus.writedata  = '0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      tick();
      idle(a);
   endtask

   task automatic expect_rd(
      input string n, input logic [31:0] e, input logic [31:0] m
   );
      sb_t s;
      s.name = n; s.exp = e; s.msk = m;
      sbq.push_back(s);
   endtask

   task automatic step();
      sb_t s;
      tick();
      if (sbq.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_underflow: got empty queue, want entry");
      end else begin
         s = sbq.pop_front();
         cmp(s.name, bus.readdata & s.msk, s.exp);
      end
   endtask

   task automatic apply(input int i);
      if (vt[i].wr) begin
         wr(vt[i].addr, vt[i].wdata);
      end else begin
         bus.chipselect = 1'b1;
         bus.write_n    = 1'b1;
         bus.address    = vt[i].addr;
      end
      expect_rd(vt[i].name, vt[i].exp_rd, 32'hFFFF_FFFF);
      step();
      cmp({vt[i].name, "_irq"}, 32'(irq), 32'(vt[i].exp_irq));
      idle(vt[i].addr);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = mk("rd_db",      2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
      vt[1]  = mk("rd_sync",    2'd1, 1'b0, 32'h0, 32'hF, 1'b0);
      vt[2]  = mk("rd_mask",    2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
      vt[3]  = mk("rd_ec",      2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
      vt[4]  = mk("wr_mask_f5", 2'd2, 1'b1, 32'hFFFF_FFF5, 32'h5, 1'b0);
      vt[5]  = mk("rd_ec2",     2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
      vt[6]  = mk("rd_mask_5",  2'd2, 1'b0, 32'h0, 32'h5, 1'b0);
      vt[7]  = mk("wr_db_ign",  2'd0, 1'b1, 32'h0, 32'hF, 1'b0);
      vt[8]  = mk("wr_sync_ign",2'd1, 1'b1, 32'h0, 32'hF, 1'b0);
      vt[9]  = mk("wr_mask_1",  2'd2, 1'b1, 32'h1, 32'h1, 1'b0);
      vt[10] = mk("mask_0",     2'd2, 1'b1, 32'h0, 32'h0, 1'b0);
      vt[11] = mk("ec_both",    2'd3, 1'b0, 32'h0, 32'h3, 1'b0);
      vt[12] = mk("mask_2",     2'd2, 1'b1, 32'h2, 32'h2, 1'b1);
      vt[13] = mk("clr_ec_b1",  2'd3, 1'b1, 32'h2, 32'h1, 1'b0);
      vt[14] = mk("mask_f",     2'd2, 1'b1, 32'hF, 32'hF, 1'b1);
      vt[15] = mk("ec_kept",    2'd3, 1'b0, 32'h0, 32'h1, 1'b1);

      reset   = 1'b1;
      in_port = 4'hF;
      idle(2'd0);
      repeat (3) tick();
      cmp("rst_readdata", bus.readdata, 32'h0);
      cmp("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) apply(i);

      // clean press on bit 0, irqmask = 0x1
      idle(2'd0);
      in_port = 4'b1110;
      for (int k = 1; k <= 7; k++) begin
         expect_rd("press_db0", (k < 7) ? 32'h1 : 32'h0, 32'h1);
         step();
         cmp("press_irq_low", 32'(irq), 32'h0);
      end
      idle(2'd3);
      expect_rd("press_ec", 32'h1, 32'hF);
      step();
      cmp("press_irq", 32'(irq), 32'h1);
      wr(2'd3, 32'h1);
      expect_rd("press_clr", 32'h0, 32'hF);
      step();
      cmp("press_clr_irq", 32'(irq), 32'h0);
      in_port = 4'hF;
      repeat (10) tick();
      expect_rd("release_no_evt", 32'h0, 32'hF);
      step();

      // three-cycle glitch on bit 1
      wr(2'd2, 32'hF);
      idle(2'd0);
      in_port = 4'b1101;
      for (int k = 0; k < 12; k++) begin
         if (k == 3) in_port = 4'hF;
         expect_rd("glitch_db", 32'hF, 32'hF);
         step();
         cmp("glitch_irq", 32'(irq), 32'h0);
      end
      idle(2'd3);
      expect_rd("glitch_ec", 32'h0, 32'hF);
      step();

      // clear lands in the same cycle as bit 2's press
      wr(2'd2, 32'h4);
      idle(2'd0);
      in_port = 4'b1011;
      repeat (6) tick();
      wr(2'd3, 32'h4);
      expect_rd("collide_ec", 32'h4, 32'hF);
      step();
      cmp("collide_irq", 32'(irq), 32'h1);
      expect_rd("collide_ec_hold", 32'h4, 32'hF);
      step();
      cmp("collide_irq_hold", 32'(irq), 32'h1);
      in_port = 4'hF;
      repeat (10) tick();
      wr(2'd3, 32'hF);

      // mask and clear with bits 0 and 1 captured
      in_port = 4'b1100;
      repeat (10) tick();
      for (int i = 10; i < 16; i++) apply(i);
      in_port = 4'hF;
      repeat (10) tick();
      wr(2'd3, 32'hF);

      // reset lands while bit 3 is mid-count
      idle(2'd0);
      in_port = 4'b0111;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      cmp("rst_mid_rd", bus.readdata, 32'h0);
      cmp("rst_mid_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         expect_rd("rst_db3", (k < 7) ? 32'h8 : 32'h0, 32'h8);
         step();
      end
      idle(2'd3);
      expect_rd("rst_ec_one", 32'h8, 32'hF);
      step();
      repeat (10) tick();
      expect_rd("rst_ec_still", 32'h8, 32'hF);
      step();
      wr(2'd3, 32'h8);
      expect_rd("rst_ec_clr", 32'h0, 32'hF);
      step();
      repeat (10) tick();
      expect_rd("rst_no_second", 32'h0, 32'hF);
      step();
      cmp("end_irq", 32'(irq), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
